// File: rtl/pdm_mic_clock_ctrl.sv
// PDM microphone clock generator and stereo capture sequencer.
// Two mics share one data line; mic 0 is taken after the rising edge, mic 1 after the falling edge.
module pdm_mic_clock_ctrl #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_DLY    = 10,
    parameter int WAKEUP_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_pdm_data,
    output logic o_pdm_clk,
    output logic o_data_0,
    output logic o_data_1,
    output logic o_data_valid,
    output logic o_mic_active,
    output logic o_busy
);

    localparam int PERIOD = 2 * CLK_DIV;
    localparam int PHW    = $clog2(PERIOD);
    localparam int WCW    = (WAKEUP_CYCLES < 1) ? 1 : $clog2(WAKEUP_CYCLES + 1);
    localparam int WC_LST = (WAKEUP_CYCLES > 0) ? WAKEUP_CYCLES - 1 : 0;

    localparam logic [PHW-1:0] PH_END  = PHW'(PERIOD - 1);
    localparam logic [PHW-1:0] PH_HALF = PHW'(CLK_DIV);
    localparam logic [PHW-1:0] PH_CAPA = PHW'(SAMPLE_DLY);
    localparam logic [PHW-1:0] PH_CAPB = PHW'(CLK_DIV + SAMPLE_DLY);
    localparam logic [WCW-1:0] WC_LAST = WCW'(WC_LST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAKEUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [PHW-1:0] r_ph;
    logic [PHW-1:0] w_ph_next;
    logic [WCW-1:0] r_wc;
    logic           w_period_end;
    logic           w_pdm_clk_next;
    logic           r_pdm_clk;
    logic           r_sync_0;
    logic           r_sync_1;
    logic           r_h0;
    logic           r_data_0;
    logic           r_data_1;
    logic           r_data_valid;

    assign w_period_end = (r_ph == PH_END);

    // Phase advances every cycle while active; parked at zero in IDLE.
    always_comb begin
        w_ph_next = r_ph + PHW'(1);
        if (r_state == S_IDLE || w_period_end) begin
            w_ph_next = '0;
        end
    end

    // Mic clock is computed from next state/phase so the pin is a flop output.
    assign w_pdm_clk_next = (w_next_state != S_IDLE) && (w_ph_next < PH_HALF);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; en is only looked at in IDLE and at period ends.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_next_state = (WAKEUP_CYCLES == 0) ? S_RUN : S_WAKEUP;
                end
            end
            S_WAKEUP: begin
                if (w_period_end) begin
                    if (!i_en) begin
                        w_next_state = S_IDLE;
                    end else if (r_wc == WC_LAST) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_period_end && !i_en) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_mic_active = (r_state == S_RUN);
        o_busy       = (r_state != S_IDLE);
    end

    // Phase counter, wake-up period counter and registered mic clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ph      <= '0;
            r_wc      <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            r_ph      <= w_ph_next;
            r_pdm_clk <= w_pdm_clk_next;
            if (r_state != S_WAKEUP) begin
                r_wc <= '0;
            end else if (w_period_end) begin
                r_wc <= r_wc + WCW'(1);
            end
        end
    end

    // Two-flop synchronizer for the asynchronous data line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= i_pdm_data;
            r_sync_1 <= r_sync_0;
        end
    end

    // Capture mic 0 into a holding flop, then publish both bits together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h0         <= 1'b0;
            r_data_0     <= 1'b0;
            r_data_1     <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (r_state != S_IDLE && r_ph == PH_CAPA) begin
                r_h0 <= r_sync_1;
            end
            if (r_state != S_IDLE && r_ph == PH_CAPB) begin
                r_data_0     <= r_h0;
                r_data_1     <= r_sync_1;
                r_data_valid <= (r_state == S_RUN);
            end
        end
    end

    assign o_pdm_clk    = r_pdm_clk;
    assign o_data_0     = r_data_0;
    assign o_data_1     = r_data_1;
    assign o_data_valid = r_data_valid;

endmodule

// File: tb/tb_pdm_mic_clock_ctrl.sv
// Directed bench for pdm_mic_clock_ctrl with CLK_DIV=4, SAMPLE_DLY=1.
// Main instance wakes for 2 periods; a second instance has no wake-up.
module tb_pdm_mic_clock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic en2 = 1'b0;
    logic pin = 1'b0;

    logic pclk, d0, d1, dv, mact, bsy;
    logic pclk2, d02, d12, dv2, mact2, bsy2;

    int n_pass = 0;
    int n_total = 0;

    int ph = 0;
    logic prev_pclk = 1'b0;
    logic pat_hi = 1'b1;
    logic pat_lo = 1'b0;

    always #5 clk = ~clk;

    pdm_mic_clock_ctrl #(
        .CLK_DIV(4), .SAMPLE_DLY(1), .WAKEUP_CYCLES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pdm_data(pin),
        .o_pdm_clk(pclk), .o_data_0(d0), .o_data_1(d1),
        .o_data_valid(dv), .o_mic_active(mact), .o_busy(bsy)
    );

    pdm_mic_clock_ctrl #(
        .CLK_DIV(4), .SAMPLE_DLY(1), .WAKEUP_CYCLES(0)
    ) dut_z (
        .i_clk(clk), .i_rst(rst), .i_en(en2), .i_pdm_data(pin),
        .o_pdm_clk(pclk2), .o_data_0(d02), .o_data_1(d12),
        .o_data_valid(dv2), .o_mic_active(mact2), .o_busy(bsy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock; phase is tracked from pdm_clk rising edges. The line is
    // driven two phases ahead so that the synchronized line follows
    // pat_hi during PH 0..3 and pat_lo during PH 4..7.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pclk && !prev_pclk) ph = 0;
        else ph = (ph + 1) % 8;
        prev_pclk = pclk;
        pin = (((ph + 2) % 8) < 4) ? pat_hi : pat_lo;
    endtask

    initial begin
        int clk_err, early_v, first_m, first_v, last_v, nval, runt;
        logic v_d0, v_d1, b8, b9;
        bit ok;

        // Reset
        repeat (3) tick();
        chk("rst_pdm_clk", pclk, 0);
        chk("rst_valid", dv, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_mic_active", mact, 0);
        chk("rst_data_0", d0, 0);
        chk("rst_busy_z", bsy2, 0);
        rst = 1'b0;
        tick();

        // Start-up with en held; channel split mic0=1 mic1=0
        en = 1'b1;
        clk_err = 0; early_v = 0; first_m = 0; first_v = 0;
        last_v = 0; nval = 0; v_d0 = 'x; v_d1 = 'x;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) chk("start_busy", bsy, 1);
            if (pclk !== (((c - 1) % 8) < 4)) clk_err++;
            if (mact && first_m == 0) first_m = c;
            if (dv) begin
                if (c <= 16) early_v++;
                if (first_v == 0) begin
                    first_v = c;
                    v_d0 = d0;
                    v_d1 = d1;
                end
                last_v = c;
                nval++;
            end
        end
        chk("start_pdm_clk_duty", clk_err, 0);
        chk("start_no_early_valid", early_v, 0);
        chk("start_mic_active_cycle", first_m, 17);
        chk("start_first_valid", first_v, 23);
        chk("start_valid_count", nval, 3);
        chk("start_last_valid", last_v, 39);
        chk("split_a_data_0", v_d0, 1);
        chk("split_a_data_1", v_d1, 0);

        // Swapped drive: mic0=0 mic1=1
        pat_hi = 1'b0;
        pat_lo = 1'b1;
        repeat (10) tick();
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (dv) ok = 1;
        end
        chk("split_b_seen", ok, 1);
        chk("split_b_data_0", d0, 0);
        chk("split_b_data_1", d1, 1);

        // Mid-period stop at PH=2
        for (int i = 0; i < 16 && ph != 2; i++) tick();
        en = 1'b0;
        nval = 0; runt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (dv) nval++;
            if (pclk !== (ph < 4)) runt++;
            if (bsy !== 1'b1) runt++;
        end
        chk("stop_valid_count", nval, 1);
        chk("stop_no_runt", runt, 0);
        tick();
        chk("stop_pdm_clk", pclk, 0);
        chk("stop_busy", bsy, 0);
        chk("stop_mic_active", mact, 0);

        // Abort during the first wake-up period
        repeat (2) tick();
        en = 1'b1;
        nval = 0; b8 = 'x; b9 = 'x;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 2) en = 1'b0;
            if (dv) nval++;
            if (c == 8) b8 = bsy;
            if (c == 9) b9 = bsy;
        end
        chk("abort_valid_count", nval, 0);
        chk("abort_busy_period_end", b8, 1);
        chk("abort_busy_after", b9, 0);

        // Re-enable repeats the full wake-up
        repeat (3) tick();
        en = 1'b1;
        first_m = 0; first_v = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (mact && first_m == 0) first_m = c;
            if (dv && first_v == 0) first_v = c;
        end
        chk("reen_mic_active_cycle", first_m, 17);
        chk("reen_first_valid", first_v, 23);

        // Reset mid-RUN at PH=5
        for (int i = 0; i < 16 && ph != 5; i++) tick();
        chk("midrst_pre_data_1", d1, 1);
        rst = 1'b1;
        tick();
        chk("midrst_pdm_clk", pclk, 0);
        chk("midrst_valid", dv, 0);
        chk("midrst_busy", bsy, 0);
        chk("midrst_mic_active", mact, 0);
        chk("midrst_data_0", d0, 0);
        chk("midrst_data_1", d1, 0);
        rst = 1'b0;
        en = 1'b0;
        repeat (2) tick();

        // Zero wake-up instance
        en2 = 1'b1;
        tick();
        chk("zero_mic_active", mact2, 1);
        chk("zero_pdm_clk", pclk2, 1);
        first_v = 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (dv2 && first_v == 0) first_v = c;
        end
        chk("zero_first_valid", first_v, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pdm_mic_clock_ctrl.md
# pdm_mic_clock_ctrl

Clock generator and capture sequencer for a pair of PDM microphones sharing one data line. It divides the system clock to produce the microphone clock and sequences the microphones through a wake-up period. It samples the shared line at programmed offsets after each rising and falling microphone-clock edge. Each clock period it presents one bit per microphone with a single-cycle valid strobe to the downstream decimation filters.

## Interface
- CLK_DIV, 25: system clocks per half period of pdm_clk. Legal range is CLK_DIV ≥ 2. At 100 MHz the default gives 2 MHz.
- SAMPLE_DLY, 10: system clocks after a pdm_clk edge at which the synchronized line is captured. Legal range is 0 ≤ SAMPLE_DLY ≤ CLK_DIV-2.
- WAKEUP_CYCLES, 16: full pdm_clk periods discarded after enabling. 0 is legal.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- pdm_data  in  1  shared microphone data line; asynchronous to clk.
- pdm_clk  out  1  microphone clock; registered.
- data_0  out  1  mic 0 bit, captured after the rising edge.
- data_1  out  1  mic 1 bit, captured after the falling edge.
- data_valid  out  1  one-cycle strobe; data_0 and data_1 are valid with it.
- mic_active  out  1  high in RUN.
- busy  out  1  high in any state other than IDLE.

## Operation
- pdm_data passes through a 2-flop synchronizer (pdm_sync) before any use. This adds 2 cycles of pin-to-capture latency.
- The phase counter is PH, with width $clog2(2*CLK_DIV). It counts 0..2*CLK_DIV-1 and wraps to 0. It is held at 0 in IDLE.
- pdm_clk is 1 iff state ≠ IDLE and PH < CLK_DIV. The rising edge is therefore at PH=0 and the falling edge at PH=CLK_DIV.
- Capture A: at PH=SAMPLE_DLY, hold register h0 ← pdm_sync.
- Capture B: at PH=CLK_DIV+SAMPLE_DLY, data_0 ← h0, data_1 ← pdm_sync, and data_valid ← 1 only if state=RUN. data_valid is 0 on every other cycle.
- In WAKEUP, captures still occur and data_0/data_1 update, but data_valid stays 0.
- State machine (IDLE, WAKEUP, RUN). "Period end" means PH=2*CLK_DIV-1.
  - IDLE → WAKEUP when en=1. The wake counter WC is cleared and PH=0 on entry.
  - WAKEUP: WC increments at each period end. When WC reaches WAKEUP_CYCLES at a period end:
    - go to RUN if en=1;
    - go to IDLE if en=0.
  - WAKEUP with WAKEUP_CYCLES=0: IDLE goes directly to RUN.
  - WAKEUP with en=0 at any period end goes to IDLE.
  - RUN → IDLE at a period end with en=0. Otherwise stay in RUN.
- en is examined only in IDLE and at period ends. Deassertion mid-period finishes the current period, including its data_valid pulse. pdm_clk never produces a runt pulse.
- Re-enabling after IDLE always repeats the full wake-up period.
- mic_active is 1 iff state=RUN. busy is 1 iff state≠IDLE.
- Reset values: state=IDLE, PH=0, WC=0, pdm_clk=0, h0=0, data_0=0, data_1=0, data_valid=0, mic_active=0, busy=0, synchronizer flops=0.
- Reset mid-operation: all registers take their reset values at the next clk edge. pdm_clk drops immediately; a truncated pulse is accepted only on reset.

## Timing
- en=1 sampled in IDLE at edge T: at T+1, state=WAKEUP (or RUN if WAKEUP_CYCLES=0), PH=0, pdm_clk=1, busy=1.
- pdm_clk period is 2*CLK_DIV clk cycles at exactly 50% duty.
- data_valid is high for the cycle with PH=CLK_DIV+SAMPLE_DLY+1. This is exactly one pulse per period in RUN.
- The first data_valid arrives in the first RUN period, (WAKEUP_CYCLES*2*CLK_DIV)+CLK_DIV+SAMPLE_DLY+1 cycles after WAKEUP entry.
- data_0 and data_1 hold their values between captures.
- Period-end transition to IDLE: on the next cycle pdm_clk=0, busy=0, mic_active=0.

## Test plan
All scenarios use CLK_DIV=4, SAMPLE_DLY=1, WAKEUP_CYCLES=2, giving an 8-cycle period.

- **Start-up:** reset, then en=1 held.
  - pdm_clk toggles 4 high / 4 low.
  - There is no data_valid for the first 16 cycles.
  - mic_active rises at cycle 17.
  - The first data_valid occurs at cycle 17+6.
  - After that, data_valid repeats every 8 cycles.
- **Channel split:** drive pdm_data=1 during PH 0..3 and 0 during PH 4..7. Expect data_0=1, data_1=0 on every valid. With the drive swapped, expect data_0=0, data_1=1.
- **Mid-period stop:** deassert en at PH=2 in RUN.
  - That period completes, including a valid at PH=6.
  - pdm_clk is low and busy=0 one cycle after PH=7.
  - pdm_clk shows no short high pulse.
- **Abort during wake-up:** deassert en during the first WAKEUP period.
  - Go to IDLE at that period end with zero valid pulses.
  - On re-enable, a full 16-cycle wake-up precedes any valid.
- **Reset mid-RUN:** assert rst at PH=5. The next cycle shows all outputs at 0, state IDLE, and no data_valid.
- **Zero wake-up:** with WAKEUP_CYCLES=0, mic_active=1 the cycle after en is sampled, and the first valid occurs 6 cycles later.
